// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - write-only I2C target with 7-bit address match
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h20,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_pull,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       busy,
  output logic       frame_done
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_dly_q, scl_dly_d, sda_dly_q, sda_dly_d;
  logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, byte_in;
  logic       armed_q, armed_d;
  logic       got_q, got_d;
  logic       ack_phase_q, ack_phase_d;
  logic       sda_pull_q, sda_pull_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       frame_done_q, frame_done_d;

  // Synchronizer shift and edge/bus-condition detection
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_dly_d  = scl_s;
    sda_dly_d  = sda_s;
    scl_rise   = scl_s & ~scl_dly_q;
    scl_fall   = ~scl_s & scl_dly_q;
    sda_rise   = sda_s & ~sda_dly_q;
    sda_fall   = ~sda_s & sda_dly_q;
    start_det  = sda_fall & scl_s & scl_dly_q;
    stop_det   = sda_rise & scl_s & scl_dly_q;
  end

  // Synchronizers are left unreset so that a reset can never fabricate a bus edge
  always_ff @(posedge clk) begin
    scl_sync_q <= scl_sync_d;
    sda_sync_q <= sda_sync_d;
    scl_dly_q  <= scl_dly_d;
    sda_dly_q  <= sda_dly_d;
  end

  // Protocol FSM next state; START/STOP override any bit activity in the same cycle
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    armed_d      = armed_q;
    got_d        = got_q;
    ack_phase_d  = ack_phase_q;
    sda_pull_d   = sda_pull_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_first_d   = 1'b0;
    frame_done_d = 1'b0;
    byte_in      = {shift_q[6:0], sda_s};
    if (start_det) begin
      state_d     = S_ADDR;
      cnt_d       = 3'd0;
      sda_pull_d  = 1'b0;
      ack_phase_d = 1'b0;
    end else if (stop_det) begin
      state_d      = S_IDLE;
      sda_pull_d   = 1'b0;
      ack_phase_d  = 1'b0;
      frame_done_d = (state_q == S_DATA) || (state_q == S_DATA_ACK) ||
                     ((state_q == S_ADDR) && got_q);
      got_d        = 1'b0;
      armed_d      = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_DATA: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              cnt_d       = 3'd0;
              ack_phase_d = 1'b0;
              if (state_q == S_ADDR) begin
                if ((byte_in[7:1] == ADDR) && !byte_in[0]) begin
                  state_d = S_ADDR_ACK;
                  armed_d = 1'b1;
                end else begin
                  state_d = S_IGNORE;
                end
              end else begin
                rx_data_d  = byte_in;
                rx_valid_d = 1'b1;
                rx_first_d = armed_q;
                armed_d    = 1'b0;
                got_d      = 1'b1;
                state_d    = S_DATA_ACK;
              end
            end
          end
        end
        // First SCL fall after the byte grabs SDA, the next one (end of 9th clock) lets go
        S_ADDR_ACK, S_DATA_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_pull_d  = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              sda_pull_d  = 1'b0;
              ack_phase_d = 1'b0;
              cnt_d       = 3'd0;
              state_d     = S_DATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Protocol state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      shift_q      <= 8'h00;
      armed_q      <= 1'b0;
      got_q        <= 1'b0;
      ack_phase_q  <= 1'b0;
      sda_pull_q   <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_first_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      armed_q      <= armed_d;
      got_q        <= got_d;
      ack_phase_q  <= ack_phase_d;
      sda_pull_q   <= sda_pull_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_first_q   <= rx_first_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sda_pull   = sda_pull_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_first   = rx_first_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - scoreboard bench for i2c_target with randomized frames
module tb_i2c_target;
  localparam int         SS    = 2;
  localparam logic [6:0] TADDR = 7'h20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       sda_pull, rx_valid, rx_first, busy, frame_done;
  logic [7:0] rx_data;

  i2c_target #(.ADDR(TADDR), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda), .sda_pull(sda_pull),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  int         fd_expect = 0;
  logic [8:0] mon_e;

  // reference model of the frame: current segment addressed, address byte pending,
  // data received in this frame, next byte is first after address
  bit m_addressed, m_pending, m_got, m_first;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_addressed = 0; m_pending = 0; m_got = 0; m_first = 0;
  endtask

  // model decision for one complete byte; returns whether an ACK is expected
  task automatic model_byte(input logic [7:0] b, output bit ack);
    if (m_pending) begin
      ack = (b[7:1] == TADDR) && (b[0] == 1'b0);
      m_addressed = ack;
      m_pending = 0;
      if (ack) m_first = 1;
    end else begin
      ack = m_addressed;
      if (m_addressed) begin
        exp_q.push_back({m_first, b});
        m_first = 0;
        m_got = 1;
      end
    end
  endtask

  task automatic send_bit(input bit b);
    sda = b;
    tick(4);
    scl = 1'b1;
    tick(4);
    chk("pull_in_data_bit", int'(sda_pull), 0);
    tick(4);
    scl = 1'b0;
    tick(4);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_bit(b[7-i]);
  endtask

  task automatic ack_slot(input bit ack);
    sda = 1'b1;
    tick(4);
    scl = 1'b1;
    tick(4);
    chk("ack_slot_pull", int'(sda_pull), int'(ack));
    tick(4);
    scl = 1'b0;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ack;
    model_byte(b, ack);
    send_bits(b, 8);
    ack_slot(ack);
  endtask

  task automatic do_start();
    if (scl) begin
      sda = 1'b0;
      tick(8);
      scl = 1'b0;
      tick(4);
    end else begin
      sda = 1'b1;
      tick(4);
      scl = 1'b1;
      tick(4);
      sda = 1'b0;
      tick(8);
      scl = 1'b0;
      tick(4);
    end
    m_pending = 1;
    m_addressed = 0;
  endtask

  task automatic do_stop();
    sda = 1'b0;
    tick(4);
    scl = 1'b1;
    tick(4);
    if (m_addressed || (m_pending && m_got)) fd_expect++;
    sda = 1'b1;
    tick(8);
    model_reset();
  endtask

  // scoreboard monitor: pops an expectation for every strobe the DUT presents
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got data %h first %0d expected none", rx_data, rx_first);
        end else begin
          mon_e = exp_q.pop_front();
          if ({rx_first, rx_data} !== mon_e) begin
            errors++;
            $display("FAIL rx_byte: got first %0d data %h expected first %0d data %h",
                     rx_first, rx_data, mon_e[8], mon_e[7:0]);
          end
        end
      end
      if (frame_done) begin
        checks++;
        if (fd_expect == 0) begin
          errors++;
          $display("FAIL frame_done_unexpected: got pulse expected none");
        end else begin
          fd_expect--;
        end
      end
      if (rx_valid && frame_done) begin
        checks++;
        errors++;
        $display("FAIL valid_done_overlap: got both expected exclusive");
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got time limit expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_sda_pull"}, int'(sda_pull), 0);
    chk({tag, "_rx_data"}, int'(rx_data), 0);
    chk({tag, "_rx_valid"}, int'(rx_valid), 0);
    chk({tag, "_rx_first"}, int'(rx_first), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  initial begin
    bit ack;
    logic [7:0] b;
    model_reset();
    rst_n = 1'b0;
    tick(4);
    check_reset_values("reset");
    rst_n = 1'b1;
    tick(4);

    // addressed write
    do_start();
    chk("busy_after_start", int'(busy), 1);
    send_byte(8'h40);
    send_byte(8'hA5);
    send_byte(8'h3C);
    do_stop();
    tick(4);
    chk("busy_after_write", int'(busy), 0);

    // address mismatch
    do_start();
    send_byte(8'h42);
    send_byte(8'hFF);
    chk("busy_mismatch", int'(busy), 1);
    do_stop();
    tick(4);
    chk("busy_after_mismatch", int'(busy), 0);

    // read request
    do_start();
    send_byte(8'h41);
    chk("busy_read_ignore", int'(busy), 1);
    do_stop();
    tick(4);
    chk("busy_after_read", int'(busy), 0);

    // repeated START discards a partial byte
    do_start();
    send_byte(8'h40);
    send_bits(8'h96, 4);
    do_start();
    send_byte(8'h40);
    send_byte(8'h5A);
    do_stop();
    tick(4);

    // repeated START after data, then STOP while still in address phase
    do_start();
    send_byte(8'h40);
    send_byte(8'h11);
    do_start();
    do_stop();
    tick(4);
    chk("busy_after_rs_stop", int'(busy), 0);

    // reset mid-byte
    do_start();
    send_byte(8'h40);
    send_bits(8'hB7, 3);
    rst_n = 1'b0;
    tick(1);
    check_reset_values("midreset");
    rst_n = 1'b1;
    model_reset();
    b = 8'hB7 << 3;
    send_bits(b, 5);
    ack_slot(1'b0);
    do_stop();
    tick(4);
    check_reset_values("after_midreset");

    // STOP during ACK slot
    do_start();
    send_byte(8'h40);
    model_byte(8'hC3, ack);
    send_bits(8'hC3, 8);
    sda = 1'b0;
    tick(4);
    scl = 1'b1;
    tick(4);
    chk("pull_before_stop", int'(sda_pull), 1);
    if (m_addressed) fd_expect++;
    sda = 1'b1;
    tick(SS + 1);
    chk("pull_after_stop", int'(sda_pull), 0);
    tick(4);
    chk("busy_after_ack_stop", int'(busy), 0);
    model_reset();
    tick(4);

    // randomized frames
    for (int t = 0; t < 30; t++) begin
      int nseg;
      nseg = int'($urandom_range(1, 2));
      for (int s = 0; s < nseg; s++) begin
        int sel;
        int nd;
        do_start();
        sel = int'($urandom_range(0, 3));
        case (sel)
          0: b = 8'h40;
          1: b = 8'h41;
          2: b = 8'h42;
          default: b = 8'($urandom);
        endcase
        send_byte(b);
        nd = int'($urandom_range(0, 3));
        for (int d = 0; d < nd; d++) send_byte(8'($urandom));
      end
      do_stop();
      tick(6);
      chk("busy_after_random", int'(busy), 0);
    end

    tick(20);
    chk("rx_queue_drained", exp_q.size(), 0);
    chk("frame_done_drained", fd_expect, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
